// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state and requester-id types for the multiplier arbiter
package mult_pkg;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ_ID_0 = 1'b0;
    localparam req_id_t REQ_ID_1 = 1'b1;

endpackage

// File: rtl/mult_rr_arbiter.sv
// rtl/mult_rr_arbiter.sv - combinational two-way round-robin pick
module mult_rr_arbiter
    import mult_pkg::*;
(
    input  logic    req0,
    input  logic    req1,
    input  req_id_t last_served,
    output logic    grant_valid,
    output req_id_t grant_id
);

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = REQ_ID_0;
        if (req0 && req1) begin
            grant_id = (last_served == REQ_ID_0) ? REQ_ID_1 : REQ_ID_0;
        end else if (req1) begin
            grant_id = REQ_ID_1;
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - two-requester arbiter in front of a shared shift-add multiplier
module mult_arbiter
    import mult_pkg::*;
#(
    parameter int n = 4
) (
    input  logic           clock,
    input  logic           n_reset,
    input  logic           req0,
    input  logic           req1,
    input  logic [n-1:0]   a0,
    input  logic [n-1:0]   b0,
    input  logic [n-1:0]   a1,
    input  logic [n-1:0]   b1,
    output logic [n-1:0]   mul_a,
    output logic [n-1:0]   mul_b,
    output logic           mul_start,
    input  logic           mul_ready,
    input  logic [2*n-1:0] mul_product,
    output logic [2*n-1:0] result,
    output logic           done0,
    output logic           done1,
    output logic           err,
    output logic           busy
);

    localparam int CW = $clog2(n + 5);
    localparam logic [CW-1:0] SYNC_LAST = CW'(n + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(n + 3);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    req_id_t       owner;
    req_id_t       last_served;
    req_id_t       grant_id;
    logic          grant_valid;
    logic          take;
    logic          latch_product;
    logic          wd_expire;

    mult_rr_arbiter u_rr (
        .req0        (req0),
        .req1        (req1),
        .last_served (last_served),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state <= ST_SYNC;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // One counter serves both the post-reset drain and the WAIT watchdog.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        take          = 1'b0;
        latch_product = 1'b0;
        wd_expire     = 1'b0;
        case (state)
            ST_SYNC: begin
                if (cnt == SYNC_LAST) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_IDLE: begin
                if (grant_valid) begin
                    state_nxt = ST_LAUNCH;
                    take      = 1'b1;
                end
            end
            ST_LAUNCH: begin
                state_nxt = ST_WAIT;
                cnt_nxt   = '0;
            end
            ST_WAIT: begin
                if (mul_ready) begin
                    state_nxt     = ST_DONE;
                    latch_product = 1'b1;
                end else if (cnt == WAIT_LAST) begin
                    state_nxt = ST_DONE;
                    wd_expire = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_SYNC;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            mul_a       <= '0;
            mul_b       <= '0;
            result      <= '0;
            err         <= 1'b0;
            owner       <= REQ_ID_0;
            last_served <= REQ_ID_1;
        end else begin
            if (take) begin
                owner <= grant_id;
                err   <= 1'b0;
                mul_a <= (grant_id == REQ_ID_1) ? a1 : a0;
                mul_b <= (grant_id == REQ_ID_1) ? b1 : b0;
            end
            if (latch_product) begin
                result <= mul_product;
            end
            if (wd_expire) begin
                err <= 1'b1;
            end
            if (state == ST_DONE) begin
                last_served <= owner;
            end
        end
    end

    assign mul_start = (state == ST_LAUNCH);
    assign done0     = (state == ST_DONE) && (owner == REQ_ID_0);
    assign done1     = (state == ST_DONE) && (owner == REQ_ID_1);
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - randomized bench for mult_arbiter against a transaction-level model
module tb_mult_arbiter;

    localparam int N = 4;

    logic           clock;
    logic           n_reset;
    logic           req0, req1;
    logic [N-1:0]   a0, b0, a1, b1;
    logic [N-1:0]   mul_a, mul_b;
    logic           mul_start;
    logic           mul_ready;
    logic [2*N-1:0] mul_product;
    logic [2*N-1:0] result;
    logic           done0, done1, err, busy;

    mult_arbiter #(.n(N)) dut (
        .clock       (clock),
        .n_reset     (n_reset),
        .req0        (req0),
        .req1        (req1),
        .a0          (a0),
        .b0          (b0),
        .a1          (a1),
        .b1          (b1),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_start   (mul_start),
        .mul_ready   (mul_ready),
        .mul_product (mul_product),
        .result      (result),
        .done0       (done0),
        .done1       (done1),
        .err         (err),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    // Requester stimulus state
    logic           rq [2];
    logic [N-1:0]   ra [2];
    logic [N-1:0]   rb [2];
    int             mode = 0;
    bit             allow_stall = 0;
    bit             force_stall = 0;

    // Transaction-level model: one operation in flight, timed by arithmetic
    int             cyc = 0;
    int             free = 1 << 30;
    int             last = 1;
    int             exp_start = -100;
    int             exp_done = -100;
    int             exp_owner = 0;
    logic [N-1:0]   exp_a, exp_b;
    logic [2*N-1:0] exp_result = '0;
    logic           exp_err = 1'b0;
    bit             stall = 0;

    // Multiplier sequencer stub
    int             mcnt = 0;
    int             m_a = 0;
    int             m_b = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, want);
        end
    endtask

    function automatic logic [N-1:0] rand_op();
        if ($urandom_range(0, 7) == 0) return '1;
        return N'($urandom_range(0, (1 << N) - 1));
    endfunction

    task automatic drive();
        req0 = rq[0]; a0 = ra[0]; b0 = rb[0];
        req1 = rq[1]; a1 = ra[1]; b1 = rb[1];
    endtask

    task automatic step();
        bit mine_done;
        bit mine_inflight;
        int w;
        int lat;
        @(negedge clock);
        cyc++;
        check("busy", busy, cyc < free);
        check("mul_start", mul_start, cyc == exp_start);
        check("done0", done0, cyc == exp_done && exp_owner == 0);
        check("done1", done1, cyc == exp_done && exp_owner == 1);
        check("done_excl", done0 & done1, 0);
        if (cyc == exp_done) begin
            check("result", result, exp_result);
            check("err", err, exp_err);
        end
        if (cyc == exp_start) check("err_clear", err, 0);
        if (cyc >= exp_start && cyc < exp_done) begin
            check("mul_a", mul_a, exp_a);
            check("mul_b", mul_b, exp_b);
        end

        mul_ready   = (mcnt == 0) && !stall;
        mul_product = (mcnt == 0) ? (2*N)'(m_a * m_b) : (2*N)'($urandom);
        if (mul_start) begin
            m_a  = int'(mul_a);
            m_b  = int'(mul_b);
            mcnt = N;
        end else if (mcnt > 0) begin
            mcnt--;
        end

        for (int i = 0; i < 2; i++) begin
            mine_done     = (exp_owner == i) && (cyc == exp_done);
            mine_inflight = (exp_owner == i) && (cyc >= exp_start - 1) && (cyc < exp_done);
            case (mode)
                0: if (mine_done) rq[i] = 1'b0;
                1: begin
                    if (mine_done) rq[i] = 1'b0;
                    else if (mine_inflight && rq[i] && $urandom_range(0, 15) == 0) rq[i] = 1'b0;
                    else if (!rq[i] && !mine_inflight && $urandom_range(0, 3) == 0) begin
                        rq[i] = 1'b1; ra[i] = rand_op(); rb[i] = rand_op();
                    end
                end
                default: if (mine_done || !rq[i]) begin
                    rq[i] = 1'b1; ra[i] = rand_op(); rb[i] = rand_op();
                end
            endcase
        end

        if (cyc >= free && (rq[0] || rq[1])) begin
            w = (rq[0] && rq[1]) ? ((last == 0) ? 1 : 0) : (rq[1] ? 1 : 0);
            stall = force_stall || (allow_stall && $urandom_range(0, 5) == 0);
            force_stall = 0;
            lat = stall ? N + 6 : N + 3;
            exp_start = cyc + 1;
            exp_done  = cyc + lat;
            exp_owner = w;
            exp_a     = ra[w];
            exp_b     = rb[w];
            if (!stall) exp_result = ra[w] * rb[w];
            exp_err   = stall;
            free      = cyc + lat + 1;
            last      = w;
        end
        drive();
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic release_reset();
        @(negedge clock);
        cyc++;
        n_reset    = 1'b1;
        free       = cyc + N + 2;
        last       = 1;
        exp_start  = -100;
        exp_done   = -100;
        exp_result = '0;
        exp_err    = 1'b0;
        drive();
    endtask

    task automatic check_reset_outputs();
        check("rst_mul_start", mul_start, 0);
        check("rst_done0", done0, 0);
        check("rst_done1", done1, 0);
        check("rst_err", err, 0);
        check("rst_result", result, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_mul_b", mul_b, 0);
        check("rst_busy", busy, 1);
    endtask

    initial begin
        bit reached;
        n_reset = 1'b0;
        mul_ready = 1'b1;
        mul_product = '0;
        for (int i = 0; i < 2; i++) begin
            rq[i] = 1'b0; ra[i] = '0; rb[i] = '0;
        end
        drive();
        repeat (2) @(negedge clock);
        check_reset_outputs();

        // Sole requester from reset: SYNC drain, then 3*5
        rq[0] = 1'b1; ra[0] = 4'd3; rb[0] = 4'd5;
        drive();
        release_reset();
        run(20);

        // Reset during WAIT abandons requester 1's operation
        rq[1] = 1'b1; ra[1] = 4'd6; rb[1] = 4'd7;
        reached = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (exp_owner == 1 && cyc == exp_start + 2) begin
                reached = 1;
                break;
            end
        end
        check("reach_wait", reached, 1);
        #2 n_reset = 1'b0;
        #1 check_reset_outputs();
        @(negedge clock);

        // Tie straight out of reset: requester 0 first, then 1
        rq[0] = 1'b1; ra[0] = 4'd2; rb[0] = 4'd7;
        rq[1] = 1'b1; ra[1] = 4'd4; rb[1] = 4'd4;
        drive();
        release_reset();
        run(30);

        // Full-width product
        rq[0] = 1'b1; ra[0] = 4'd15; rb[0] = 4'd15;
        run(12);

        // Watchdog: ready withheld, result must stay at 225
        force_stall = 1;
        rq[1] = 1'b1; ra[1] = 4'd9; rb[1] = 4'd9;
        run(16);

        mode = 1;
        allow_stall = 1;
        run(600);

        mode = 2;
        allow_stall = 0;
        run(120);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
